// File: rtl/freq_count_latch.sv
// freq_count_latch: gated BCD edge counter with result latch for the frequency meter.
module freq_count_latch #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gate_in,
  input  logic                  sig_in,
  input  logic                  sel_ok,
  input  logic [1:0]            range_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [1:0]            range_out,
  output logic                  overflow,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam logic [CW-1:0] ALL_NINES = {DIGITS{4'h9}};

  localparam logic [1:0] WAIT_LOW  = 2'd0;
  localparam logic [1:0] WAIT_OPEN = 2'd1;
  localparam logic [1:0] COUNT     = 2'd2;
  localparam logic [1:0] LATCH     = 2'd3;

  logic [SYNC_STAGES-1:0] gate_sync_q, sig_sync_q, settle_q;
  logic                   gate_d1_q, sig_d1_q;
  logic                   gate_s, sig_s, gate_rise, gate_fall, sig_rise, settled, cnt_en;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    rng_q, rng_d;
  logic [CW-1:0] bcd_q, bcd_d;
  logic [1:0]    range_q, range_d;
  logic          ovf_out_q, ovf_out_d;
  logic          dv_q, dv_d;
  logic          busy_q, busy_d;

  // BCD increment with ripple carry across digits (caller handles all-nines)
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Input synchronizers, edge-detect registers and post-reset settle tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_sync_q <= '0;
      sig_sync_q  <= '0;
      gate_d1_q   <= 1'b0;
      sig_d1_q    <= 1'b0;
      settle_q    <= '0;
    end else begin
      gate_sync_q <= {gate_sync_q[SYNC_STAGES-2:0], gate_in};
      sig_sync_q  <= {sig_sync_q[SYNC_STAGES-2:0], sig_in};
      gate_d1_q   <= gate_s;
      sig_d1_q    <= sig_s;
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign gate_s    = gate_sync_q[SYNC_STAGES-1];
  assign sig_s     = sig_sync_q[SYNC_STAGES-1];
  assign gate_rise = gate_s & ~gate_d1_q;
  assign gate_fall = ~gate_s & gate_d1_q;
  assign sig_rise  = sig_s & ~sig_d1_q;
  assign cnt_en    = sig_rise & gate_s;
  // gate_s is only trustworthy once the synchronizer has refilled after reset,
  // so a window already open at reset release is seen as high and discarded
  assign settled   = settle_q[SYNC_STAGES-1];

  // State, counter and latched-result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOW;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rng_q     <= 2'b00;
      bcd_q     <= '0;
      range_q   <= 2'b00;
      ovf_out_q <= 1'b0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rng_q     <= rng_d;
      bcd_q     <= bcd_d;
      range_q   <= range_d;
      ovf_out_q <= ovf_out_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, counting and latch decisions
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    rng_d     = rng_q;
    bcd_d     = bcd_q;
    range_d   = range_q;
    ovf_out_d = ovf_out_q;
    dv_d      = 1'b0;

    case (state_q)
      WAIT_LOW: begin
        count_d = '0;
        ovf_d   = 1'b0;
        if (settled && !gate_s) state_d = WAIT_OPEN;
      end
      WAIT_OPEN: begin
        count_d = '0;
        ovf_d   = 1'b0;
        if (gate_rise && sel_ok) begin
          rng_d   = range_in;
          state_d = COUNT;
          // the opening cycle itself may carry a signal edge
          count_d = CW'(cnt_en);
        end
      end
      COUNT: begin
        if (!sel_ok || (range_in != rng_q)) begin
          state_d = WAIT_LOW;
        end else if (gate_fall) begin
          state_d   = LATCH;
          bcd_d     = count_q;
          range_d   = rng_q;
          ovf_out_d = ovf_q;
          dv_d      = 1'b1;
        end else if (cnt_en) begin
          if (count_q == ALL_NINES) ovf_d   = 1'b1;
          else                      count_d = bcd_inc(count_q);
        end
      end
      default: begin
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = WAIT_OPEN;
      end
    endcase

    busy_d = (state_d == COUNT);
  end

  assign bcd_out    = bcd_q;
  assign range_out  = range_q;
  assign overflow   = ovf_out_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_freq_count_latch.sv
// Directed self-checking bench for freq_count_latch (DIGITS=4, SYNC_STAGES=2).
module tb_freq_count_latch;

  logic        clk;
  logic        rst;
  logic        gate_in;
  logic        sig_in;
  logic        sel_ok;
  logic [1:0]  range_in;
  logic [15:0] bcd_out;
  logic [1:0]  range_out;
  logic        overflow;
  logic        data_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int dv_cnt   = 0;
  int exp_dv   = 0;

  freq_count_latch #(.DIGITS(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .gate_in    (gate_in),
    .sig_in     (sig_in),
    .sel_ok     (sel_ok),
    .range_in   (range_in),
    .bcd_out    (bcd_out),
    .range_out  (range_out),
    .overflow   (overflow),
    .data_valid (data_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count data_valid cycles, sampled mid-cycle
  always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n signal pulses (lo low, hi high) inside a gate window; gate stays high at exit
  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b0; cyc(lo);
      sig_in = 1'b1; cyc(hi);
    end
    sig_in = 1'b0;
    cyc(2);
  endtask

  // Close the gate and allow latch plus a low gap before the next window
  task automatic close_gate();
    gate_in = 1'b0;
    cyc(10);
  endtask

  task automatic window(input int n, input int hi, input int lo, input logic [1:0] rng);
    range_in = rng;
    gate_in  = 1'b1;
    pulses(n, hi, lo);
    check("busy_in_window", 32'(busy), 32'd1);
    close_gate();
  endtask

  initial begin
    rst = 1'b1; gate_in = 1'b0; sig_in = 1'b0; sel_ok = 1'b1; range_in = 2'b01;

    // Reset with toggling inputs: all outputs idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      gate_in = ~gate_in;
      sig_in  = ~sig_in;
      check("reset_outputs", 32'({bcd_out, range_out, overflow, data_valid, busy}), 32'd0);
    end
    gate_in = 1'b0; sig_in = 1'b0; rst = 1'b0;
    cyc(1);
    check("post_reset_outputs", 32'({bcd_out, range_out, overflow, data_valid, busy}), 32'd0);
    cyc(5);

    // Basic window: 1000 clk gate, period 10 -> 100 edges
    window(100, 5, 5, 2'b01);
    exp_dv += 1;
    check("basic_dv", 32'(dv_cnt), 32'(exp_dv));
    check("basic_bcd", 32'(bcd_out), 32'h0100);
    check("basic_range", 32'(range_out), 32'h1);
    check("basic_ovf", 32'(overflow), 32'd0);
    check("basic_busy_idle", 32'(busy), 32'd0);

    // Carry and back-to-back windows
    window(999, 2, 2, 2'b01);
    exp_dv += 1;
    check("w999_bcd", 32'(bcd_out), 32'h0999);
    window(1000, 2, 2, 2'b10);
    exp_dv += 1;
    check("w1000_bcd", 32'(bcd_out), 32'h1000);
    check("w1000_range", 32'(range_out), 32'h2);
    check("b2b_dv", 32'(dv_cnt), 32'(exp_dv));

    // Overflow saturates and is cleared by the next window
    window(10005, 2, 2, 2'b11);
    exp_dv += 1;
    check("ovf_bcd", 32'(bcd_out), 32'h9999);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_range", 32'(range_out), 32'h3);
    window(7, 2, 2, 2'b01);
    exp_dv += 1;
    check("after_ovf_bcd", 32'(bcd_out), 32'h0007);
    check("after_ovf_flag", 32'(overflow), 32'd0);
    check("after_ovf_dv", 32'(dv_cnt), 32'(exp_dv));

    // Abort via sel_ok glitch after a result of 0042
    window(42, 2, 2, 2'b01);
    exp_dv += 1;
    check("pre_abort_bcd", 32'(bcd_out), 32'h0042);
    range_in = 2'b01;
    gate_in  = 1'b1;
    pulses(10, 2, 2);
    sel_ok = 1'b0; cyc(1); sel_ok = 1'b1;
    pulses(10, 2, 2);
    close_gate();
    check("abort_dv", 32'(dv_cnt), 32'(exp_dv));
    check("abort_bcd", 32'(bcd_out), 32'h0042);
    check("abort_busy", 32'(busy), 32'd0);
    window(5, 2, 2, 2'b01);
    exp_dv += 1;
    check("post_abort_bcd", 32'(bcd_out), 32'h0005);
    check("post_abort_dv", 32'(dv_cnt), 32'(exp_dv));

    // Abort via range change mid-window
    range_in = 2'b10;
    gate_in  = 1'b1;
    pulses(6, 2, 2);
    range_in = 2'b01;
    pulses(6, 2, 2);
    close_gate();
    check("rng_abort_dv", 32'(dv_cnt), 32'(exp_dv));
    check("rng_abort_bcd", 32'(bcd_out), 32'h0005);
    check("rng_abort_range", 32'(range_out), 32'h1);

    // Reset mid-window with gate still high at release
    range_in = 2'b10;
    gate_in  = 1'b1;
    pulses(20, 2, 2);
    rst = 1'b1; cyc(2); rst = 1'b0;
    pulses(20, 2, 2);
    check("midrst_busy", 32'(busy), 32'd0);
    close_gate();
    check("midrst_dv", 32'(dv_cnt), 32'(exp_dv));
    check("midrst_outputs", 32'({bcd_out, range_out, overflow}), 32'd0);
    window(13, 2, 2, 2'b11);
    exp_dv += 1;
    check("post_rst_bcd", 32'(bcd_out), 32'h0013);
    check("post_rst_range", 32'(range_out), 32'h3);
    check("post_rst_dv", 32'(dv_cnt), 32'(exp_dv));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
